// File: rtl/fetch_pkg.sv
// fetch_pkg: fetch FSM state encoding and default PC/NOP constants
package fetch_pkg;
  typedef enum logic [1:0] {REQ, WAIT, HOLD} fetch_state_e;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0000;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response handshake
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  modport master(output req, addr, input ready, rvalid, rdata);
  modport slave(input req, addr, output ready, rvalid, rdata);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with stall hold buffer and redirect squash; FETCH_TRACE_EN adds fetch/squash trace prints
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_target,
  fetch_unit_if.master      imem,
  output logic [31:0]       PC_plus_4_out,
  output logic [31:0]       inst_out,
  output logic              inst_valid
);
  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d, hold_q, hold_d, pc4_q, pc4_d, inst_q, inst_d, word, target, pc_next;
  logic         squash_q, squash_d, valid_q, valid_d, deliver;
  assign target        = {redirect_target[31:2], 2'b00};
  assign pc_next       = pc_q + 32'd4;
  assign imem.req      = (state_q == REQ) & ~redirect_valid;
  assign imem.addr     = pc_q;
  assign PC_plus_4_out = pc4_q;
  assign inst_out      = inst_q;
  assign inst_valid    = valid_q;
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    squash_d = squash_q;
    hold_d   = hold_q;
    deliver  = 1'b0;
    word     = hold_q;
    case (state_q)
      REQ: begin
        if (redirect_valid) pc_d = target;
        else if (imem.ready) state_d = WAIT;
      end
      WAIT: begin
        word = imem.rdata;
        if (redirect_valid) begin
          pc_d     = target;
          squash_d = ~imem.rvalid;
          state_d  = imem.rvalid ? REQ : WAIT;
        end else if (imem.rvalid) begin
          squash_d = 1'b0;
          hold_d   = imem.rdata;
          deliver  = ~squash_q & ~stall;
          state_d  = (~squash_q & stall) ? HOLD : REQ;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = target;
          state_d = REQ;
        end else if (~stall) begin
          deliver = 1'b1;
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase
    if (deliver) pc_d = pc_next;
    // redirect forces a bubble even under stall; stall alone freezes the outputs
    pc4_d   = deliver ? pc_next : pc4_q;
    inst_d  = (stall & ~redirect_valid) ? inst_q : deliver ? word : NOP_INST;
    valid_d = (stall & ~redirect_valid) ? valid_q : deliver;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= REQ;
      pc_q     <= RESET_PC;
      squash_q <= 1'b0;
      hold_q   <= '0;
      pc4_q    <= '0;
      inst_q   <= NOP_INST;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      squash_q <= squash_d;
      hold_q   <= hold_d;
      pc4_q    <= pc4_d;
      inst_q   <= inst_d;
      valid_q  <= valid_d;
    end
  end
`ifdef FETCH_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst && deliver) $display("IF fetch pc=%h inst=%h", pc_q, word);
    if (!rst && state_q == WAIT && redirect_valid && !imem.rvalid) $display("IF squash pc=%h", pc_q);
  end
`else
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenario tests for fetch_unit
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, stall, redirect_valid;
  logic [31:0] redirect_target, pc4, inst;
  logic        valid;
  int          checks = 0;
  int          errors = 0;
  fetch_unit_if bus();
  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .imem(bus),
    .PC_plus_4_out(pc4), .inst_out(inst), .inst_valid(valid)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1; stall = 0; redirect_valid = 0; redirect_target = 0;
    bus.ready = 0; bus.rvalid = 0; bus.rdata = 0;
    step(); step();
    rst = 0; #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %h exp 0", valid); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h exp 0", inst); end
    checks++; if (pc4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 got %h exp 0", pc4); end
    checks++; if (bus.req !== 1'b1) begin errors++; $display("FAIL reset_req got %h exp 1", bus.req); end
    checks++; if (bus.addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", bus.addr); end
  endtask
  task automatic test_basic_fetch();
    bus.ready = 1; #1;
    checks++; if (bus.addr !== 32'h0) begin errors++; $display("FAIL basic_addr got %h exp 0", bus.addr); end
    step();
    bus.ready = 0; bus.rvalid = 1; bus.rdata = 32'h2008_0005; #1;
    checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL basic_req_wait got %h exp 0", bus.req); end
    step();
    bus.rvalid = 0; #1;
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %h exp 1", valid); end
    checks++; if (inst !== 32'h2008_0005) begin errors++; $display("FAIL basic_inst got %h exp 20080005", inst); end
    checks++; if (pc4 !== 32'h4) begin errors++; $display("FAIL basic_pc4 got %h exp 4", pc4); end
    checks++; if (bus.addr !== 32'h4) begin errors++; $display("FAIL basic_next_addr got %h exp 4", bus.addr); end
  endtask
  task automatic test_stall();
    stall = 1; bus.ready = 1;
    step();
    bus.ready = 0; bus.rvalid = 1; bus.rdata = 32'hA5A5_0013;
    step();
    bus.rvalid = 0; bus.rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d] got %h exp 0", i, bus.req); end
      checks++; if (valid !== 1'b1 || inst !== 32'h2008_0005 || pc4 !== 32'h4) begin errors++; $display("FAIL stall_hold[%0d] got v=%h i=%h p=%h exp v=1 i=20080005 p=4", i, valid, inst, pc4); end
    end
    stall = 0;
    step();
    checks++; if (valid !== 1'b1 || inst !== 32'hA5A5_0013) begin errors++; $display("FAIL stall_release got v=%h i=%h exp v=1 i=a5a50013", valid, inst); end
    checks++; if (pc4 !== 32'h8) begin errors++; $display("FAIL stall_pc4 got %h exp 8", pc4); end
    checks++; if (bus.addr !== 32'h8) begin errors++; $display("FAIL stall_next_addr got %h exp 8", bus.addr); end
  endtask
  task automatic test_redirect_wait();
    bus.ready = 1;
    step();
    bus.ready = 0; redirect_valid = 1; redirect_target = 32'h0000_0103;
    step();
    redirect_valid = 0; bus.rvalid = 1; bus.rdata = 32'hDEAD_BEEF;
    checks++; if (bus.addr !== 32'h100) begin errors++; $display("FAIL redir_wait_addr got %h exp 100", bus.addr); end
    step();
    bus.rvalid = 0; #1;
    checks++; if (valid !== 1'b0 || inst !== 32'h0) begin errors++; $display("FAIL redir_drop got v=%h i=%h exp v=0 i=0", valid, inst); end
    checks++; if (bus.req !== 1'b1 || bus.addr !== 32'h100) begin errors++; $display("FAIL redir_next got req=%h a=%h exp req=1 a=100", bus.req, bus.addr); end
  endtask
  task automatic test_redirect_rvalid_same();
    bus.ready = 1;
    step();
    bus.ready = 0; redirect_valid = 1; redirect_target = 32'h0000_0200; bus.rvalid = 1; bus.rdata = 32'hBAD0_BAD0;
    step();
    redirect_valid = 0; bus.rvalid = 0; #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL same_drop got %h exp 0", valid); end
    checks++; if (bus.req !== 1'b1 || bus.addr !== 32'h200) begin errors++; $display("FAIL same_next got req=%h a=%h exp req=1 a=200", bus.req, bus.addr); end
    bus.ready = 1;
    step();
    bus.ready = 0; bus.rvalid = 1; bus.rdata = 32'h0123_4567;
    step();
    bus.rvalid = 0; #1;
    checks++; if (valid !== 1'b1 || inst !== 32'h0123_4567) begin errors++; $display("FAIL same_no_squash got v=%h i=%h exp v=1 i=01234567", valid, inst); end
    checks++; if (pc4 !== 32'h204 || bus.addr !== 32'h204) begin errors++; $display("FAIL same_pc got p=%h a=%h exp 204", pc4, bus.addr); end
  endtask
  task automatic test_wrap();
    redirect_valid = 1; redirect_target = 32'hFFFF_FFFF; #1;
    checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL wrap_req_redirect got %h exp 0", bus.req); end
    step();
    redirect_valid = 0; bus.ready = 1; #1;
    checks++; if (bus.addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got %h exp fffffffc", bus.addr); end
    step();
    bus.ready = 0; bus.rvalid = 1; bus.rdata = 32'h0000_0013;
    step();
    bus.rvalid = 0; #1;
    checks++; if (valid !== 1'b1 || pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got v=%h p=%h exp v=1 p=0", valid, pc4); end
    checks++; if (bus.addr !== 32'h0) begin errors++; $display("FAIL wrap_next_addr got %h exp 0", bus.addr); end
  endtask
  task automatic test_reset_in_wait();
    redirect_valid = 1; redirect_target = 32'h40;
    step();
    redirect_valid = 0; bus.ready = 1;
    step();
    bus.ready = 0; rst = 1;
    step();
    rst = 0; bus.rvalid = 1; bus.rdata = 32'h5A5A_5A5A;
    step();
    bus.rvalid = 0; #1;
    checks++; if (valid !== 1'b0 || inst !== 32'h0 || pc4 !== 32'h0) begin errors++; $display("FAIL stale_ignored got v=%h i=%h p=%h exp 0", valid, inst, pc4); end
    checks++; if (bus.req !== 1'b1 || bus.addr !== 32'h0) begin errors++; $display("FAIL stale_addr got req=%h a=%h exp req=1 a=0", bus.req, bus.addr); end
    bus.ready = 1;
    step();
    bus.ready = 0; bus.rvalid = 1; bus.rdata = 32'h00C0_FFEE;
    step();
    bus.rvalid = 0; #1;
    checks++; if (valid !== 1'b1 || inst !== 32'h00C0_FFEE || pc4 !== 32'h4) begin errors++; $display("FAIL post_reset_fetch got v=%h i=%h p=%h exp v=1 i=00c0ffee p=4", valid, inst, pc4); end
  endtask
  initial begin
    test_reset();
    test_basic_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_rvalid_same();
    test_wrap();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
